// File: rtl/fetch_queue.sv
// fetch_queue: byte-wide prefetch queue feeding the decoder; owns eip and handles jmp redirects.
// Define FETCH_FAULT_EN to enable the sticky illegal-advance fault flag.
module fetch_queue #(
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 8,
    parameter logic [ADDR_W-1:0] RESET_EIP = '0
) (
    input  logic              clk2,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       ope,
    output logic              ope_valid,
    input  logic              adv,
    input  logic [3:0]        adv_len,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0] eip,
    output logic              fault
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int XW = CW + 4;

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [7:0]        q_q [DEPTH];
    logic [7:0]        q_d [DEPTH];
    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] eip_q, eip_d;
    logic              mem_req_q, mem_req_d;
    logic              fault_q, fault_d;
    logic              wr_en, retire;
    logic [XW-1:0]     adv_x, cnt_x;

    always_comb begin
        adv_x        = XW'(adv_len);
        cnt_x        = XW'(count_q);
        wr_en        = (state_q == S_WAIT) && mem_ack && !jmp;
        retire       = adv && !jmp && (adv_len != 4'd0) && (adv_x <= cnt_x);
        q_d          = q_q;
        if (wr_en) q_d[wr_q] = mem_rdata;
        wr_d         = jmp ? '0 : wr_en ? wr_q + PW'(1) : wr_q;
        rd_d         = jmp ? '0 : retire ? PW'(XW'(rd_q) + adv_x) : rd_q;
        count_d      = jmp ? '0 : CW'(cnt_x + XW'(wr_en) - (retire ? adv_x : '0));
        eip_d        = jmp ? jmp_addr : retire ? eip_q + ADDR_W'(adv_len) : eip_q;
        fetch_addr_d = jmp ? jmp_addr : wr_en ? fetch_addr_q + ADDR_W'(1) : fetch_addr_q;
        // A jmp with no ack leaves a request in flight that must still complete at its old address.
        case (state_q)
            S_RUN:   state_d = (!jmp && count_q < CW'(DEPTH)) ? S_WAIT : S_RUN;
            S_WAIT:  state_d = jmp ? (mem_ack ? S_RUN : S_DRAIN)
                             : !mem_ack ? S_WAIT
                             : (count_d < CW'(DEPTH)) ? S_WAIT : S_RUN;
            S_DRAIN: state_d = mem_ack ? S_RUN : S_DRAIN;
            default: state_d = S_RUN;
        endcase
        mem_req_d    = state_d != S_RUN;
        mem_addr_d   = (state_d == S_DRAIN) ? mem_addr_q : fetch_addr_d;
`ifdef FETCH_FAULT_EN
        fault_d      = jmp ? 1'b0 : (fault_q | (adv && adv_x > cnt_x));
`else
        fault_d      = 1'b0;
`endif
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state_q      <= S_RUN;
            q_q          <= '{default: '0};
            rd_q         <= '0;
            wr_q         <= '0;
            count_q      <= '0;
            fetch_addr_q <= RESET_EIP;
            mem_addr_q   <= RESET_EIP;
            eip_q        <= RESET_EIP;
            mem_req_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_q          <= q_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            count_q      <= count_d;
            fetch_addr_q <= fetch_addr_d;
            mem_addr_q   <= mem_addr_d;
            eip_q        <= eip_d;
            mem_req_q    <= mem_req_d;
            fault_q      <= fault_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign eip       = eip_q;
    assign fault     = fault_q;
    assign ope_valid = count_q >= CW'(5);
    assign ope       = {q_q[rd_q], q_q[rd_q + PW'(1)], q_q[rd_q + PW'(2)], q_q[rd_q + PW'(3)]};
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage that sits directly upstream of the decoder. It pulls bytes from a byte-wide instruction memory into a small circular prefetch queue and presents the next four bytes as `ope[31:0]`, with the opcode in `ope[31:24]`. Once the decoder has sized the instruction, it retires that many bytes through `adv`/`adv_len`. The block owns the architectural `eip` and handles redirects for `call`/`ret`.

## Interface
- `ADDR_W`, 32, width of byte addresses and `eip`.
- `DEPTH`, 8, queue capacity in bytes; power of two; minimum 8.
- `RESET_EIP`, 32'h0, `eip` and fetch address after reset.
- `clk2`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  read request; held until acknowledged.
- `mem_addr`  out  ADDR_W  byte address; stable while `mem_req`=1.
- `mem_rdata`  in  8  read byte; valid when `mem_ack`=1.
- `mem_ack`  in  1  read complete; only meaningful while `mem_req`=1.
- `ope`  out  32  `{q[rd], q[rd+1], q[rd+2], q[rd+3]}`.
- `ope_valid`  out  1  count ≥ 5; a complete maximum-length (5-byte) instruction is buffered.
- `adv`  in  1  retire `adv_len` bytes this cycle.
- `adv_len`  in  4  bytes to retire (0 = no-op).
- `jmp`  in  1  redirect: flush the queue and refetch from `jmp_addr`.
- `jmp_addr`  in  ADDR_W  redirect target.
- `eip`  out  ADDR_W  address of `ope[31:24]`.
- `fault`  out  1  sticky illegal-advance flag.

## Operation
- State: byte array `q[DEPTH]`, read pointer `rd`, write pointer `wr`, `count` (0..DEPTH), `fetch_addr`, FSM {RUN, WAIT, DRAIN}.
- RUN:
  - If `count` < DEPTH: assert `mem_req` with `mem_addr`=`fetch_addr` and go to WAIT.
  - Otherwise stay in RUN with `mem_req`=0.
- WAIT:
  - `mem_req`=1.
  - On `mem_ack`: write `mem_rdata` to `q[wr]`, increment `wr` and `fetch_addr`.
  - If the next cycle still has room (`count`+1−retired < DEPTH), remain in WAIT with the new address (back-to-back). Otherwise go to RUN.
- DRAIN:
  - Entered when `jmp` arrives while WAIT is pending without `mem_ack` in the same cycle.
  - `mem_req` stays 1 at the old address until `mem_ack`. The returned byte is discarded, then the FSM goes to RUN.
  - A `jmp` in DRAIN only updates the target.
- Advance (no `jmp`): when `adv`=1 and 1 ≤ `adv_len` ≤ `count`:
  - `rd` += `adv_len` (mod DEPTH); `eip` += `adv_len` (mod 2^ADDR_W).
- Illegal advance: `adv`=1 with `adv_len` > `count` is ignored; pointers and `eip` are unchanged.
- Simultaneous write and advance: `count` ← `count` + write − `adv_len`.
- Jump:
  - `jmp` has priority over `adv` and over a same-cycle ack byte, which is dropped.
  - `rd`=`wr`=0, `count`=0.
  - `eip` and `fetch_addr` ← `jmp_addr`.
- `ope` bytes beyond `count` are don't-care; consumers qualify with `ope_valid`.
- Pointers wrap modulo DEPTH; addresses wrap modulo 2^ADDR_W.

## Timing
- Reset (asynchronous, `reset`=0):
  - `mem_req`=0, `mem_addr`=`RESET_EIP`, `eip`=`RESET_EIP`.
  - `count`=0, `ope_valid`=0, `fault`=0, `ope`=0, FSM=RUN.
  - An in-flight request is abandoned; any late `mem_ack` after release is ignored because `mem_req` is 0.
- `mem_req` rises on the first `clk2` edge after reset deassertion.
- Fetch latency: a byte acked at edge N counts toward `count`/`ope_valid` at edge N (visible after N). Sustained throughput is 1 byte/cycle with zero-wait memory.
- First `ope_valid`: 5 acks after the first request. With a zero-wait memory, that is edge 6 after reset release.
- Full queue: `mem_req` is 0 while `count`=DEPTH. It re-asserts the cycle after any advance that frees space.
- `jmp` at edge N: outputs reflect the new `eip` after N. A new request goes out at edge N+1, or one cycle after the drain ack.

## Configuration
- `FETCH_FAULT_EN` defined: an illegal advance sets `fault`=1 at that edge. `fault` stays set until `jmp` or reset clears it.
- `FETCH_FAULT_EN` undefined: `fault` is constant 0. Illegal advances are still silently ignored.

## Test plan
- Reset then release, zero-wait memory holding 55 89 e5 b8 2a 00 00 00 at address 0:
  - `mem_addr` steps 0,1,2,… and `ope_valid` rises after the 5th ack.
  - `ope`=32'h5589e5b8, `eip`=0.
- `adv`=1, `adv_len`=1 → `ope`=32'h89e5b82a, `eip`=1. Then `adv_len`=2 → `ope`=32'hb82a0000, `eip`=3.
- Memory never retires bytes (no `adv`) → `count` reaches 8, `mem_req`=0. One `adv_len`=5 → `mem_req` returns next cycle at address 8.
- `jmp`=1, `jmp_addr`=32'h40 while a request is pending with `mem_ack` delayed 3 cycles:
  - `mem_req` stays at the old address until ack, and that byte is discarded.
  - Next request is to 32'h40; `eip`=32'h40, `count`=0.
- With `FETCH_FAULT_EN`: `count`=3, `adv_len`=5 → `fault`=1, `eip` unchanged. A later `jmp` clears `fault`.
- Pulse `reset`=0 mid-WAIT → all outputs go to their reset values immediately, without a clock.
- `eip`=32'hFFFFFFFE, `adv_len`=3 → `eip`=1.
